// File: rtl/can_pkg.sv
// can_pkg: shared CAN frame constants and transmitter state encoding
package can_pkg;
    localparam logic [14:0] CRC15_POLY = 15'h4599;
    localparam int ID_STD      = 11;
    localparam int ID_EXT_HI   = 11;
    localparam int ID_EXT_LO   = 18;
    localparam int DLC_W       = 4;
    localparam int CRC_W       = 15;
    localparam int EOF_LEN     = 7;
    localparam int IFS_LEN     = 3;
    localparam int STUFF_RUN   = 5;
    // SOF + ID + RTR/IDE/r0 + DLC, and SOF + ID_HI + SRR/IDE + ID_LO + RTR/r1/r0 + DLC
    localparam int HDR_STD_LEN = 1 + ID_STD + 3 + DLC_W;
    localparam int HDR_EXT_LEN = 1 + ID_EXT_HI + 2 + ID_EXT_LO + 3 + DLC_W;
    // CRC delimiter, ACK slot, ACK delimiter, EOF, IFS
    localparam int TAIL_LEN    = 3 + EOF_LEN + IFS_LEN;

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_DATA, S_CRC, S_STUFF, S_TAIL, S_DONE
    } tx_state_t;
endpackage

// File: rtl/can_crc15_serial.sv
// can_crc15_serial: bit-serial CAN CRC-15 accumulator
module can_crc15_serial
    import can_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    // shift one message bit into the remainder
    always_comb begin
        fb    = bit_i ^ crc_q[CRC_W-1];
        crc_d = clear_i ? '0 : en_i ? ({crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC15_POLY : '0)) : crc_q;
    end

    // remainder register
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) crc_q <= '0;
        else           crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/can_frame_tx.sv
// can_frame_tx: serialises one CAN 2.0A/2.0B frame per valid/ready transfer
module can_frame_tx
    import can_pkg::*;
#(
    parameter int CLK_DIV   = 200,
    parameter int MAX_BYTES = 8,
    parameter bit EXT_ID_EN = 1'b1
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [28:0]            id_i,
    input  logic                   ide_i,
    input  logic                   rtr_i,
    input  logic [3:0]             dlc_i,
    input  logic [8*MAX_BYTES-1:0] data_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int DW = $clog2(CLK_DIV);

    tx_state_t              state_q, state_d, ret_q, ret_d, nxt;
    logic [DW-1:0]          div_q, div_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             run_q, run_d, run_n;
    logic                   last_q, last_d;
    logic [HDR_EXT_LEN-1:0] hdr_q;
    logic [63:0]            data_q;
    logic [3:0]             nbytes_q, nbytes_req;
    logic                   ext_q, ext_req;
    logic                   xfer, tick, field_end, stuffable, crc_en, tx_bit;
    logic [CRC_W-1:0]       crc;

    assign ready_o    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign done_o     = state_q == S_DONE;
    assign busy_o     = state_q inside {S_HEADER, S_DATA, S_CRC, S_STUFF, S_TAIL};
    assign xfer       = valid_i && ready_o;
    assign tick       = busy_o && (div_q == DW'(CLK_DIV - 1));
    assign div_d      = (xfer || !busy_o || tick) ? '0 : div_q + DW'(1);
    assign ext_req    = EXT_ID_EN && ide_i;
    assign nbytes_req = rtr_i ? 4'd0 : (dlc_i > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc_i;
    assign stuffable  = state_q inside {S_HEADER, S_DATA, S_CRC};
    assign crc_en     = tick && (state_q == S_HEADER || state_q == S_DATA);
    assign tx_o       = tx_bit;

    can_crc15_serial u_crc (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .clear_i (xfer),
        .en_i    (crc_en),
        .bit_i   (tx_bit),
        .crc_o   (crc)
    );

    // capture the request; standard headers are left-aligned in the header register
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hdr_q    <= '0;
            data_q   <= '0;
            nbytes_q <= '0;
            ext_q    <= 1'b0;
        end else if (xfer) begin
            hdr_q    <= ext_req ? {1'b0, id_i[28:18], 2'b11, id_i[17:0], rtr_i, 2'b00, dlc_i}
                                : {1'b0, id_i[ID_STD-1:0], rtr_i, 2'b00, dlc_i,
                                   {(HDR_EXT_LEN - HDR_STD_LEN){1'b0}}};
            data_q   <= 64'(data_i);
            nbytes_q <= nbytes_req;
            ext_q    <= ext_req;
        end
    end

    // FSM, bit-tick divider and stuffing history
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            last_q  <= last_d;
        end
    end

    // current bit, field sequencing and stuff-bit insertion
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        last_d    = last_q;
        nxt       = S_IDLE;
        tx_bit    = 1'b1;
        field_end = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_HEADER: begin
                tx_bit    = hdr_q[6'(HDR_EXT_LEN - 1) - cnt_q[5:0]];
                field_end = cnt_q == (ext_q ? 8'(HDR_EXT_LEN - 1) : 8'(HDR_STD_LEN - 1));
                nxt       = (nbytes_q == 4'd0) ? S_CRC : S_DATA;
            end
            S_DATA: begin
                tx_bit    = data_q[{cnt_q[5:3], ~cnt_q[2:0]}];
                field_end = cnt_q == {1'b0, nbytes_q, 3'b000} - 8'd1;
                nxt       = S_CRC;
            end
            S_CRC: begin
                tx_bit    = crc[4'(CRC_W - 1) - cnt_q[3:0]];
                field_end = cnt_q == 8'(CRC_W - 1);
                nxt       = S_TAIL;
            end
            S_STUFF: tx_bit = ~last_q;
            S_TAIL: begin
                field_end = cnt_q == 8'(TAIL_LEN - 1);
                nxt       = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        run_n = (tx_bit == last_q) ? run_q + 3'd1 : 3'd1;
        if (tick && state_q != S_STUFF) begin
            cnt_d   = field_end ? '0 : cnt_q + 8'd1;
            state_d = field_end ? nxt : state_q;
        end
        if (tick && stuffable) begin
            run_d  = run_n;
            last_d = tx_bit;
            ret_d  = state_d;
            if (run_n == 3'(STUFF_RUN)) state_d = S_STUFF;
        end
        if (tick && state_q == S_STUFF) begin
            state_d = ret_q;
            run_d   = 3'd1;
            last_d  = ~last_q;
        end
        if (xfer) begin
            state_d = S_HEADER;
            cnt_d   = '0;
            run_d   = '0;
            last_d  = 1'b1;
        end
    end
endmodule

// File: tb/tb_can_frame_tx.sv
// tb_can_frame_tx: scoreboard bench decoding the CAN TX line against a bit-level frame model
module tb_can_frame_tx;
    localparam int DIV = 4;

    logic        clock_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ide_i = 1'b0;
    logic        rtr_i = 1'b0;
    logic [28:0] id_i = '0;
    logic [3:0]  dlc_i = '0;
    logic [63:0] data_i = '0;
    logic        ready_o, tx_o, busy_o, done_o;

    int checks = 0, failures = 0, pushed = 0, dones = 0;

    typedef struct {
        logic [255:0] raw;
        int           raw_len;
        logic [255:0] stf;
        int           stf_len;
        int           tag;
    } exp_t;
    exp_t sb[$];

    can_frame_tx #(.CLK_DIV(DIV), .MAX_BYTES(8), .EXT_ID_EN(1'b1)) dut (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .id_i    (id_i),
        .ide_i   (ide_i),
        .rtr_i   (rtr_i),
        .dlc_i   (dlc_i),
        .data_i  (data_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // golden frame: unstuffed SOF..CRC sequence and the full stuffed line sequence with tail
    function automatic void build(input logic [28:0] id, input logic ide, input logic rtr,
                                  input logic [3:0] dlc, input logic [63:0] data, output exp_t e);
        bit          b[$];
        logic [14:0] c;
        logic        fb, last;
        int          n, run;
        n = rtr ? 0 : (dlc > 8 ? 8 : int'(dlc));
        b.push_back(1'b0);
        if (ide) begin
            for (int i = 28; i >= 18; i--) b.push_back(id[i]);
            b.push_back(1'b1);
            b.push_back(1'b1);
            for (int i = 17; i >= 0; i--) b.push_back(id[i]);
            b.push_back(rtr);
            b.push_back(1'b0);
            b.push_back(1'b0);
        end else begin
            for (int i = 10; i >= 0; i--) b.push_back(id[i]);
            b.push_back(rtr);
            b.push_back(1'b0);
            b.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) b.push_back(dlc[i]);
        for (int k = 0; k < n; k++)
            for (int i = 7; i >= 0; i--) b.push_back(data[8*k+i]);
        c = '0;
        foreach (b[i]) begin
            fb = b[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (fb) c = c ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) b.push_back(c[i]);
        e.raw = '0;
        e.raw_len = b.size();
        foreach (b[i]) e.raw[i] = b[i];
        e.stf = '0;
        e.stf_len = 0;
        run = 0;
        last = 1'b1;
        foreach (b[i]) begin
            e.stf[e.stf_len] = b[i];
            e.stf_len++;
            if (b[i] == last) run++;
            else begin
                run = 1;
                last = b[i];
            end
            if (run == 5) begin
                e.stf[e.stf_len] = ~last;
                e.stf_len++;
                last = ~last;
                run = 1;
            end
        end
        for (int i = 0; i < 13; i++) begin
            e.stf[e.stf_len] = 1'b1;
            e.stf_len++;
        end
    endfunction

    // remove stuff bits from a captured line sequence until need data bits are recovered
    function automatic void destuff(input logic [255:0] s, input int need, output logic [255:0] r);
        int   i, j, run;
        logic last;
        r = '0;
        i = 0;
        j = 0;
        run = 0;
        last = 1'b1;
        while (j < need && i < 256) begin
            r[j] = s[i];
            j++;
            if (s[i] == last) run++;
            else begin
                run = 1;
                last = s[i];
            end
            i++;
            if (run == 5) begin
                i++;
                last = ~last;
                run = 1;
            end
        end
    endfunction

    logic [255:0] got;
    int           cyc = 0, nb = 0, hold_err = 0;
    logic         cur = 1'b1, in_f = 1'b0;

    task automatic score();
        exp_t         e;
        logic [255:0] r;
        int           mism;
        chk("frame_expected", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk($sformatf("f%0d_cycles", e.tag), cyc, e.stf_len * DIV);
        chk($sformatf("f%0d_hold_errors", e.tag), hold_err, 0);
        chk($sformatf("f%0d_done_pulse", e.tag), done_o, 1);
        mism = 0;
        for (int i = 0; i < e.stf_len; i++) if (got[i] !== e.stf[i]) mism++;
        chk($sformatf("f%0d_stream_bad_bits", e.tag), mism, 0);
        destuff(got, e.raw_len, r);
        mism = 0;
        for (int i = 0; i < e.raw_len; i++) if (r[i] !== e.raw[i]) mism++;
        chk($sformatf("f%0d_destuffed_bad_bits", e.tag), mism, 0);
    endtask

    // monitor: sample tx_o every cycle, one bit per DIV cycles, score when busy_o drops
    always @(negedge clock_i) begin
        if (done_o) dones++;
        if (!reset_ni) in_f = 1'b0;
        else if (!in_f) begin
            if (busy_o) begin
                in_f = 1'b1;
                got = '0;
                got[0] = tx_o;
                cur = tx_o;
                nb = 1;
                cyc = 1;
                hold_err = 0;
            end
        end else if (busy_o) begin
            if (cyc % DIV == 0) begin
                if (nb < 256) got[nb] = tx_o;
                cur = tx_o;
                nb++;
            end else if (tx_o !== cur) hold_err++;
            cyc++;
        end else begin
            in_f = 1'b0;
            score();
        end
    end

    task automatic drive(input logic [28:0] id, input logic ide, input logic rtr, input logic [3:0] dlc,
                         input logic [63:0] data, input bit push, input int tag);
        exp_t e;
        id_i = id;
        ide_i = ide;
        rtr_i = rtr;
        dlc_i = dlc;
        data_i = data;
        valid_i = 1'b1;
        if (push) begin
            build(id, ide, rtr, dlc, data, e);
            e.tag = tag;
            sb.push_back(e);
            pushed++;
        end
    endtask

    task automatic wait_xfer(output logic dn);
        int n = 0;
        while (!ready_o && n < 3000) begin
            @(negedge clock_i);
            n++;
        end
        chk("xfer_within_bound", n < 3000, 1);
        dn = done_o;
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic send(input logic [28:0] id, input logic ide, input logic rtr, input logic [3:0] dlc,
                        input logic [63:0] data, input int tag);
        logic dn;
        drive(id, ide, rtr, dlc, data, 1'b1, tag);
        wait_xfer(dn);
        valid_i = 1'b0;
    endtask

    initial begin
        logic dn;
        int   n;
        repeat (3) @(negedge clock_i);
        chk("rst_tx", tx_o, 1);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        reset_ni = 1'b1;
        @(negedge clock_i);
        send(29'h123, 1'b0, 1'b0, 4'd2, 64'h0FA5, 1);
        send(29'h7FF, 1'b0, 1'b0, 4'd0, 64'h0, 2);
        send(29'h1ABCDEF0, 1'b1, 1'b0, 4'd8, 64'h0, 3);
        send(29'h555, 1'b0, 1'b1, 4'd5, 64'hDEADBEEF, 4);
        send(29'h0AA, 1'b0, 1'b0, 4'd15, 64'h0123456789ABCDEF, 5);
        drive(29'h00000001, 1'b1, 1'b0, 4'd1, 64'h3C, 1'b1, 6);
        wait_xfer(dn);
        drive(29'h321, 1'b0, 1'b0, 4'd1, 64'h5A, 1'b1, 7);
        chk("held_ready_low", ready_o, 0);
        wait_xfer(dn);
        chk("held_accept_on_done", dn, 1);
        chk("held_sof_busy", busy_o, 1);
        chk("held_sof_low", tx_o, 0);
        valid_i = 1'b0;
        drive(29'h2AA, 1'b0, 1'b0, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        wait_xfer(dn);
        valid_i = 1'b0;
        repeat (30 * DIV) @(negedge clock_i);
        chk("abort_busy_before", busy_o, 1);
        #2 reset_ni = 1'b0;
        #1;
        chk("abort_tx", tx_o, 1);
        chk("abort_ready", ready_o, 1);
        chk("abort_busy", busy_o, 0);
        @(negedge clock_i);
        @(negedge clock_i);
        #2 reset_ni = 1'b1;
        @(negedge clock_i);
        send(29'h123, 1'b0, 1'b0, 4'd2, 64'h0FA5, 8);
        n = 0;
        while ((sb.size() != 0 || busy_o) && n < 5000) begin
            @(negedge clock_i);
            n++;
        end
        repeat (3) @(negedge clock_i);
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_count", dones, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
